// File: rtl/vmem_local_seq_if.sv
// Bundle of the command, element-stream, memory port A and load-result signals of vmem_local_seq.
// slave = sequencer side, master = issue stage / memory side.
interface vmem_local_seq_if #(
   parameter int NUMLANES     = 8,
   parameter int DATAWORDSIZE = 16,
   parameter int LOGMEMDEPTH  = 11,
   parameter int VCWIDTH      = 32,
   parameter int VLWIDTH      = 7
) ();
   logic                             cmd_valid;
   logic                             cmd_ready;
   logic [6:0]                       cmd_op;
   logic [LOGMEMDEPTH-1:0]           cmd_base;
   logic [VCWIDTH-1:0]               cmd_stride;
   logic [VLWIDTH-1:0]               cmd_vl;
   logic                             elem_valid;
   logic                             elem_ready;
   logic [NUMLANES*DATAWORDSIZE-1:0] elem_data;
   logic [NUMLANES*16-1:0]           elem_offset;
   logic                             mem_en;
   logic [6:0]                       mem_op;
   logic [LOGMEMDEPTH-1:0]           mem_address;
   logic [VCWIDTH-1:0]               mem_stride;
   logic [NUMLANES*16-1:0]           mem_offset;
   logic [NUMLANES*DATAWORDSIZE-1:0] mem_data;
   logic [NUMLANES-1:0]              mem_lane_en;
   logic [NUMLANES*DATAWORDSIZE-1:0] mem_out;
   logic                             rd_valid;
   logic [NUMLANES*DATAWORDSIZE-1:0] rd_data;
   logic [NUMLANES-1:0]              rd_mask;
   logic                             rd_last;
   logic                             done;

   modport slave (
      input  cmd_valid, cmd_op, cmd_base, cmd_stride, cmd_vl,
      input  elem_valid, elem_data, elem_offset, mem_out,
      output cmd_ready, elem_ready, mem_en, mem_op, mem_address, mem_stride,
      output mem_offset, mem_data, mem_lane_en, rd_valid, rd_data, rd_mask, rd_last, done
   );

   modport master (
      output cmd_valid, cmd_op, cmd_base, cmd_stride, cmd_vl,
      output elem_valid, elem_data, elem_offset, mem_out,
      input  cmd_ready, elem_ready, mem_en, mem_op, mem_address, mem_stride,
      input  mem_offset, mem_data, mem_lane_en, rd_valid, rd_data, rd_mask, rd_last, done
   );
endinterface

// File: rtl/vmem_local_seq.sv
// Sequences one vector memory instruction onto lane-parallel local memory, one NUMLANES chunk per cycle.
// Optional VMEM_LOCAL_SEQ_PERF_EN adds busy/stall performance counters.
module vmem_local_seq #(
   parameter int NUMLANES     = 8,
   parameter int DATAWORDSIZE = 16,
   parameter int LOGMEMDEPTH  = 11,
   parameter int VCWIDTH      = 32,
   parameter int VLWIDTH      = 7
) (
   input  logic        clk,
   input  logic        reset,
`ifdef VMEM_LOCAL_SEQ_PERF_EN
   input  logic        perf_clr,
   output logic [31:0] perf_busy,
   output logic [31:0] perf_stall,
`endif
   vmem_local_seq_if.slave bus
);
   localparam int LOGLANES = $clog2(NUMLANES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [6:0]             op_q;
   logic [LOGMEMDEPTH-1:0] addr_q;
   logic [LOGMEMDEPTH-1:0] step_q;
   logic [LOGMEMDEPTH-1:0] step_s;
   logic [VCWIDTH-1:0]     stride_q;
   logic [VLWIDTH-1:0]     rem_q;
   logic                   rd_valid_q;
   logic                   rd_last_q;
   logic [NUMLANES-1:0]    rd_mask_q;
   logic [NUMLANES-1:0]    lane_en_s;
   logic                   accept_s;
   logic                   issue_s;
   logic                   stall_s;
   logic                   needs_elem_s;
   logic                   last_s;
   logic                   is_load_s;

   assign accept_s     = (state_q == S_IDLE) && bus.cmd_valid;
   assign needs_elem_s = op_q[0] | op_q[5];
   assign is_load_s    = ~op_q[0];
   // rem_q counts elements still to issue, so the final chunk is the one holding at most NUMLANES.
   assign last_s       = (rem_q <= VLWIDTH'(NUMLANES));

   // Address step per chunk: NUMLANES for unit, NUMLANES*stride for strided, 0 for indexed.
   always_comb begin
      step_s = '0;
      case (bus.cmd_op[5:4])
         2'b00:   step_s = LOGMEMDEPTH'(NUMLANES);
         2'b01:   step_s = LOGMEMDEPTH'(bus.cmd_stride << LOGLANES);
         default: step_s = '0;
      endcase
   end

   // Lane enables for the current chunk.
   always_comb begin
      lane_en_s = '0;
      for (int i = 0; i < NUMLANES; i++) begin
         lane_en_s[i] = (rem_q > VLWIDTH'(i));
      end
   end

   // Next-state and issue/stall decode.
   always_comb begin
      state_d = state_q;
      issue_s = 1'b0;
      stall_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               if ((bus.cmd_vl == '0) || !bus.cmd_op[6]) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ISSUE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (needs_elem_s && !bus.elem_valid) begin
               stall_s = 1'b1;
               state_d = S_ISSUE;
            end else begin
               issue_s = 1'b1;
               if (last_s) begin
                  state_d = is_load_s ? S_DRAIN : S_DONE;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Command latch, chunk address/remaining-count advance and load-result tags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q       <= 7'd0;
         stride_q   <= '0;
         addr_q     <= '0;
         step_q     <= '0;
         rem_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_mask_q  <= '0;
         rd_last_q  <= 1'b0;
      end else begin
         if (accept_s) begin
            op_q     <= bus.cmd_op;
            stride_q <= bus.cmd_stride;
            addr_q   <= bus.cmd_base;
            step_q   <= step_s;
            rem_q    <= bus.cmd_vl;
         end else if (issue_s) begin
            addr_q <= addr_q + step_q;
            rem_q  <= last_s ? '0 : (rem_q - VLWIDTH'(NUMLANES));
         end
         rd_valid_q <= issue_s & is_load_s;
         rd_mask_q  <= (issue_s & is_load_s) ? lane_en_s : '0;
         rd_last_q  <= issue_s & is_load_s & last_s;
      end
   end

   assign bus.cmd_ready   = (state_q == S_IDLE);
   assign bus.elem_ready  = issue_s & needs_elem_s;
   assign bus.mem_en      = issue_s;
   assign bus.mem_op      = op_q;
   assign bus.mem_stride  = stride_q;
   assign bus.mem_address = issue_s ? addr_q : '0;
   assign bus.mem_lane_en = issue_s ? lane_en_s : '0;
   assign bus.mem_offset  = issue_s ? bus.elem_offset : '0;
   assign bus.mem_data    = issue_s ? bus.elem_data : '0;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_valid_q ? bus.mem_out : '0;
   assign bus.rd_mask     = rd_mask_q;
   assign bus.rd_last     = rd_last_q;
   assign bus.done        = (state_q == S_DONE);

`ifdef VMEM_LOCAL_SEQ_PERF_EN
   logic [31:0] busy_q;
   logic [31:0] stall_cnt_q;

   // Saturating busy and stall counters with synchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q      <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else if (perf_clr) begin
         busy_q      <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         if ((state_q != S_IDLE) && (busy_q != 32'hFFFF_FFFF)) begin
            busy_q <= busy_q + 32'd1;
         end
         if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign perf_busy  = busy_q;
   assign perf_stall = stall_cnt_q;
`endif
endmodule

// File: tb/tb_vmem_local_seq.sv
// Directed scoreboard bench for vmem_local_seq: expected issues, load results and done pulses are
// queued at command time and matched cycle-exactly by a negedge monitor.
`timescale 1ns/1ps
module tb_vmem_local_seq;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   typedef struct {
      int          cyc;
      logic [10:0] addr;
      logic [7:0]  lane;
      logic        needs;
      logic [6:0]  op;
   } iss_t;

   typedef struct {
      int          cyc;
      logic [7:0]  mask;
      logic        last;
      logic [10:0] addr;
   } rd_t;

   iss_t iq[$];
   rd_t  rq[$];
   int   dq[$];
   iss_t m_ie;
   rd_t  m_re;
   int   m_dc;

   vmem_local_seq_if bus ();

`ifdef VMEM_LOCAL_SEQ_PERF_EN
   logic        perf_clr;
   logic [31:0] perf_busy;
   logic [31:0] perf_stall;
`endif

   vmem_local_seq dut (
      .clk        (clk),
      .reset      (reset),
`ifdef VMEM_LOCAL_SEQ_PERF_EN
      .perf_clr   (perf_clr),
      .perf_busy  (perf_busy),
      .perf_stall (perf_stall),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Read data pattern of the bench memory at a given chunk address.
   function automatic logic [127:0] mk(input logic [10:0] a);
      logic [127:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i*16 +: 16] = (16'(a) * 16'd8 + 16'(i)) ^ 16'hA5A5;
      end
      return r;
   endfunction

   always @(posedge clk) bus.mem_out <= bus.mem_en ? mk(bus.mem_address) : 128'd0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycle-exact scoreboard matching of DUT output events.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.mem_en) begin
            if (iq.size() == 0) begin
               check("mem_en_unexpected", 128'(bus.mem_en), 128'd0);
            end else begin
               m_ie = iq.pop_front();
               check("issue_cycle", 128'(cyc), 128'(m_ie.cyc));
               check("mem_address", 128'(bus.mem_address), 128'(m_ie.addr));
               check("mem_lane_en", 128'(bus.mem_lane_en), 128'(m_ie.lane));
               check("elem_ready", 128'(bus.elem_ready), 128'(m_ie.needs));
               check("mem_op", 128'(bus.mem_op), 128'(m_ie.op));
               check("mem_offset", bus.mem_offset, bus.elem_offset);
               if (m_ie.op[0]) check("mem_data", bus.mem_data, bus.elem_data);
            end
         end else begin
            check("elem_ready_noissue", 128'(bus.elem_ready), 128'd0);
            check("lane_en_noissue", 128'(bus.mem_lane_en), 128'd0);
         end
         if (bus.rd_valid) begin
            if (rq.size() == 0) begin
               check("rd_valid_unexpected", 128'(bus.rd_valid), 128'd0);
            end else begin
               m_re = rq.pop_front();
               check("rd_cycle", 128'(cyc), 128'(m_re.cyc));
               check("rd_mask", 128'(bus.rd_mask), 128'(m_re.mask));
               check("rd_last", 128'(bus.rd_last), 128'(m_re.last));
               check("rd_data", bus.rd_data, mk(m_re.addr));
            end
         end
         if (bus.done) begin
            if (dq.size() == 0) begin
               check("done_unexpected", 128'(bus.done), 128'd0);
            end else begin
               m_dc = dq.pop_front();
               check("done_cycle", 128'(cyc), 128'(m_dc));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Queue the reference events of one command whose cycle 0 is cyc value a.
   task automatic expect_cmd(input logic [6:0] op, input logic [10:0] base, input logic [31:0] stride,
                             input logic [6:0] vl, input int stall, input int a);
      int          n;
      longint      t;
      logic [10:0] addr;
      logic [7:0]  lane;
      n = (int'(vl) + 7) / 8;
      if (vl == 7'd0 || !op[6]) begin
         dq.push_back(a + 1);
      end else begin
         for (int k = 0; k < n; k++) begin
            if (op[5])      t = longint'(base);
            else if (op[4]) t = longint'(base) + longint'(k) * 64'sd8 * longint'(stride);
            else            t = longint'(base) + longint'(k) * 64'sd8;
            addr = t[10:0];
            for (int i = 0; i < 8; i++) lane[i] = ((k * 8 + i) < int'(vl));
            iq.push_back('{a + 1 + stall + k, addr, lane, op[0] | op[5], op});
            if (!op[0]) rq.push_back('{a + 2 + stall + k, lane, (k == n - 1), addr});
         end
         dq.push_back(op[0] ? (a + n + 1 + stall) : (a + n + 2 + stall));
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (iq.size() == 0 && rq.size() == 0 && dq.size() == 0) break;
         step();
      end
      check("timeout_pending", 128'(iq.size() + rq.size() + dq.size()), 128'd0);
      check("cmd_ready_after", 128'(bus.cmd_ready), 128'd1);
   endtask

   task automatic send(input logic [6:0] op, input logic [10:0] base, input logic [31:0] stride,
                       input logic [6:0] vl, input int stall, input logic ev);
      expect_cmd(op, base, stride, vl, stall, cyc);
      bus.cmd_op      = op;
      bus.cmd_base    = base;
      bus.cmd_stride  = stride;
      bus.cmd_vl      = vl;
      bus.cmd_valid   = 1'b1;
      bus.elem_data   = {$urandom, $urandom, $urandom, $urandom};
      bus.elem_offset = {$urandom, $urandom, $urandom, $urandom};
      bus.elem_valid  = (stall == 0) ? ev : 1'b0;
      step();
      bus.cmd_valid = 1'b0;
      repeat (stall) step();
      bus.elem_valid = ev;
      wait_idle();
      bus.elem_valid = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_cmd_ready"}, 128'(bus.cmd_ready), 128'd1);
      check({tag, "_mem_en"}, 128'(bus.mem_en), 128'd0);
      check({tag, "_mem_addr"}, 128'(bus.mem_address), 128'd0);
      check({tag, "_lane_en"}, 128'(bus.mem_lane_en), 128'd0);
      check({tag, "_mem_op"}, 128'(bus.mem_op), 128'd0);
      check({tag, "_elem_ready"}, 128'(bus.elem_ready), 128'd0);
      check({tag, "_rd_valid"}, 128'(bus.rd_valid), 128'd0);
      check({tag, "_rd_mask"}, 128'(bus.rd_mask), 128'd0);
      check({tag, "_rd_last"}, 128'(bus.rd_last), 128'd0);
      check({tag, "_rd_data"}, bus.rd_data, 128'd0);
      check({tag, "_done"}, 128'(bus.done), 128'd0);
   endtask

   initial begin
      int a;
      reset           = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_op      = 7'd0;
      bus.cmd_base    = 11'd0;
      bus.cmd_stride  = 32'd0;
      bus.cmd_vl      = 7'd0;
      bus.elem_valid  = 1'b0;
      bus.elem_data   = 128'd0;
      bus.elem_offset = 128'd0;
`ifdef VMEM_LOCAL_SEQ_PERF_EN
      perf_clr = 1'b0;
`endif
      step();
      step();
      check_quiet("reset");
      reset = 1'b0;
      step();

      // Unit load vl=20, element stream held low and ignored.
      send(7'b1000100, 11'd100, 32'd0, 7'd20, 0, 1'b0);
      // Strided store wrapping past the top of memory.
      send(7'b1010101, 11'd2040, 32'd3, 7'd16, 0, 1'b1);
      // Strided load with a single-lane final chunk.
      send(7'b1010100, 11'd0, 32'd2, 7'd9, 0, 1'b0);

      // Indexed load stalled three cycles on the element stream.
`ifdef VMEM_LOCAL_SEQ_PERF_EN
      perf_clr = 1'b1;
      step();
      perf_clr = 1'b0;
`endif
      send(7'b1100100, 11'd50, 32'd0, 7'd8, 3, 1'b1);
`ifdef VMEM_LOCAL_SEQ_PERF_EN
      check("perf_busy", 128'(perf_busy), 128'd6);
      check("perf_stall", 128'(perf_stall), 128'd3);
`endif

      // Zero-length and non-memory commands complete without issuing.
      send(7'b1000100, 11'd10, 32'd0, 7'd0, 0, 1'b1);
      send(7'b0000101, 11'd10, 32'd0, 7'd5, 0, 1'b1);

      // Reset in the middle of a three-chunk load.
      expect_cmd(7'b1000100, 11'd300, 32'd0, 7'd20, 0, cyc);
      bus.cmd_op    = 7'b1000100;
      bus.cmd_base  = 11'd300;
      bus.cmd_vl    = 7'd20;
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      #5;
      check("pre_reset_issued", 128'(iq.size()), 128'd2);
      reset = 1'b1;
      #1;
      check_quiet("midreset");
      iq.delete();
      rq.delete();
      dq.delete();
      step();
      reset = 1'b0;
      repeat (5) step();
      check("post_reset_ready", 128'(bus.cmd_ready), 128'd1);

      // cmd_valid held: second command accepted only once the first completes.
      a = cyc;
      expect_cmd(7'b1000100, 11'd200, 32'd0, 7'd8, 0, a);
      bus.cmd_op    = 7'b1000100;
      bus.cmd_base  = 11'd200;
      bus.cmd_vl    = 7'd8;
      bus.cmd_valid = 1'b1;
      step();
      for (int t = 1; t <= 3; t++) begin
         check("cmd_ready_busy", 128'(bus.cmd_ready), 128'd0);
         step();
      end
      check("cmd_ready_cycle4", 128'(bus.cmd_ready), 128'd1);
      bus.cmd_base = 11'd208;
      expect_cmd(7'b1000100, 11'd208, 32'd0, 7'd8, 0, a + 4);
      step();
      bus.cmd_valid = 1'b0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
